// File: rtl/param_address_register_file_pkg.sv
// Shared definitions for the address register file: operation encodings
// and the fixed roles of the low register indices.
package param_address_register_file_pkg;

    // Operation applied to every enabled register on a clock edge
    typedef enum logic [2:0] {
        FS_DEC   = 3'b000,
        FS_INC   = 3'b001,
        FS_LOAD  = 3'b010,
        FS_CLR   = 3'b011,
        FS_LO_Z  = 3'b100,
        FS_LO    = 3'b101,
        FS_HI    = 3'b110,
        FS_LO_SX = 3'b111
    } fun_sel_e;

    // Dedicated register indices; everything above IDX_SP is general purpose
    localparam int unsigned IDX_PC = 0;
    localparam int unsigned IDX_AR = 1;
    localparam int unsigned IDX_SP = 2;

endpackage

// File: rtl/param_address_register_file_arf_register.sv
// Single address register: wrap-around inc/dec, full and half-word loads,
// clear. Holds when not enabled; resets asynchronously to RESET_VAL.
module arf_register
    import param_address_register_file_pkg::*;
#(
    parameter int unsigned     WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic             E,
    input  logic [2:0]       FunSel,
    output logic [WIDTH-1:0] Q
);

    localparam int unsigned H = WIDTH / 2;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value from the selected operation; hold when disabled
    always_comb begin
        q_d = q_q;
        if (E) begin
            case (FunSel)
                FS_DEC:   q_d = q_q - WIDTH'(1);
                FS_INC:   q_d = q_q + WIDTH'(1);
                FS_LOAD:  q_d = I;
                FS_CLR:   q_d = '0;
                FS_LO_Z:  q_d = {{H{1'b0}}, I[H-1:0]};
                FS_LO:    q_d = {q_q[WIDTH-1:H], I[H-1:0]};
                FS_HI:    q_d = {I[H-1:0], q_q[H-1:0]};
                FS_LO_SX: q_d = {{H{I[H-1]}}, I[H-1:0]};
                default:  q_d = q_q;
            endcase
        end
    end

    // Register state with asynchronous reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/param_address_register_file.sv
// Address register file: PC, AR, SP and general registers, two combinational
// read ports, and sticky stack overflow/underflow flags tracking SP.
module param_address_register_file
    import param_address_register_file_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      NREG     = 4,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter logic [WIDTH-1:0] SP_HIGH  = '1,
    parameter logic [WIDTH-1:0] SP_LOW   = WIDTH'(16'hFF00),
    localparam int unsigned     SEL      = $clog2(NREG)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [NREG-1:0]  RegSel,
    input  logic [2:0]       FunSel,
    input  logic [SEL-1:0]   OutCSel,
    input  logic [SEL-1:0]   OutDSel,
    input  logic             ClearFlags,
    output logic [WIDTH-1:0] OutC,
    output logic [WIDTH-1:0] OutD,
    output logic             SPOverflow,
    output logic             SPUnderflow
);

    logic [WIDTH-1:0] regs [NREG];

    genvar k;
    generate
        for (k = 0; k < NREG; k++) begin : g_reg
            localparam logic [WIDTH-1:0] RV = (k == IDX_PC) ? PC_RESET :
                                              (k == IDX_SP) ? SP_HIGH  : '0;
            arf_register #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RV)
            ) u_reg (
                .Clock  (Clock),
                .Reset  (Reset),
                .I      (I),
                .E      (~RegSel[k]),
                .FunSel (FunSel),
                .Q      (regs[k])
            );
        end
    endgenerate

    // Read ports: out-of-range selects return zero
    always_comb begin
        OutC = '0;
        OutD = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (OutCSel == SEL'(r)) OutC = regs[r];
            if (OutDSel == SEL'(r)) OutD = regs[r];
        end
    end

    logic sp_en;
    logic ovf_set;
    logic unf_set;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    assign sp_en   = ~RegSel[IDX_SP];
    assign ovf_set = sp_en && (FunSel == FS_DEC) && (regs[IDX_SP] == SP_LOW);
    assign unf_set = sp_en && (FunSel == FS_INC) && (regs[IDX_SP] == SP_HIGH);

    // Sticky flag next state: a set event takes priority over ClearFlags
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (ovf_set)         ovf_d = 1'b1;
        else if (ClearFlags) ovf_d = 1'b0;
        if (unf_set)         unf_d = 1'b1;
        else if (ClearFlags) unf_d = 1'b0;
    end

    // Flag state with asynchronous reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign SPOverflow  = ovf_q;
    assign SPUnderflow = unf_q;

endmodule

// File: tb/tb_param_address_register_file.sv
// Directed bench for the address register file at default parameters.
module tb_param_address_register_file;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] I;
    logic [3:0]  RegSel;
    logic [2:0]  FunSel;
    logic [1:0]  OutCSel;
    logic [1:0]  OutDSel;
    logic        ClearFlags;
    logic [15:0] OutC;
    logic [15:0] OutD;
    logic        SPOverflow;
    logic        SPUnderflow;

    int n_tests = 0;
    int n_fail  = 0;

    param_address_register_file #(
        .WIDTH (16),
        .NREG  (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .I           (I),
        .RegSel      (RegSel),
        .FunSel      (FunSel),
        .OutCSel     (OutCSel),
        .OutDSel     (OutDSel),
        .ClearFlags  (ClearFlags),
        .OutC        (OutC),
        .OutD        (OutD),
        .SPOverflow  (SPOverflow),
        .SPUnderflow (SPUnderflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read register r through port C and compare
    task automatic rd(input int r, input logic [15:0] exp, input string tag);
        OutCSel = 2'(r);
        #1;
        chk(tag, OutC, exp);
    endtask

    task automatic flags(input logic ovf, input logic unf, input string tag);
        chk({tag, "_ovf"}, {15'b0, SPOverflow}, {15'b0, ovf});
        chk({tag, "_unf"}, {15'b0, SPUnderflow}, {15'b0, unf});
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; I = '0; RegSel = 4'b1111; FunSel = 3'b000;
        OutCSel = 2'd0; OutDSel = 2'd0; ClearFlags = 1'b0;
        tick(); tick();
        Reset = 1'b0;

        // Reset values
        rd(0, 16'h0000, "rst_pc");
        rd(1, 16'h0000, "rst_ar");
        rd(2, 16'hFFFF, "rst_sp");
        rd(3, 16'h0000, "rst_r3");
        flags(1'b0, 1'b0, "rst");

        // Asynchronous reset clears a loaded AR without a clock edge
        RegSel = 4'b1101; FunSel = 3'b010; I = 16'h1234; OutCSel = 2'd1;
        tick();
        chk("ar_load_1234", OutC, 16'h1234);
        RegSel = 4'b1111;
        Reset = 1'b1; #1;
        chk("async_rst_ar", OutC, 16'h0000);
        Reset = 1'b0;

        // Full load then high-half load, read-before-write on port C
        RegSel = 4'b1101; FunSel = 3'b010; I = 16'hABCD; OutCSel = 2'd1; OutDSel = 2'd0;
        #1;
        chk("pre_edge_ar", OutC, 16'h0000);
        tick();
        chk("load_abcd", OutC, 16'hABCD);
        chk("outd_pc", OutD, 16'h0000);
        FunSel = 3'b110; I = 16'h0012;
        #1;
        chk("pre_edge_hi", OutC, 16'hABCD);
        tick();
        chk("hi_12cd", OutC, 16'h12CD);
        chk("outd_pc2", OutD, 16'h0000);

        // Half-word loads
        FunSel = 3'b010; I = 16'h00F0; tick();
        FunSel = 3'b111; I = 16'h0080; tick();
        chk("sx_neg", OutC, 16'hFF80);
        I = 16'h007F; tick();
        chk("sx_pos", OutC, 16'h007F);
        FunSel = 3'b010; I = 16'hABCD; tick();
        FunSel = 3'b100; I = 16'h0055; tick();
        chk("lo_zero", OutC, 16'h0055);
        FunSel = 3'b010; I = 16'hABCD; tick();
        FunSel = 3'b101; I = 16'h1234; tick();
        chk("lo_hold", OutC, 16'hAB34);
        FunSel = 3'b011; tick();
        chk("clr_ar", OutC, 16'h0000);

        // Stack overflow at SP_LOW
        RegSel = 4'b1011; FunSel = 3'b010; I = 16'hFF01; OutCSel = 2'd2; tick();
        FunSel = 3'b000; tick();
        chk("dec_ff00", OutC, 16'hFF00);
        flags(1'b0, 1'b0, "dec1");
        tick();
        chk("dec_feff", OutC, 16'hFEFF);
        flags(1'b1, 1'b0, "dec2");
        RegSel = 4'b1111; ClearFlags = 1'b1; tick();
        flags(1'b0, 1'b0, "clr_idle");
        ClearFlags = 1'b0; RegSel = 4'b1011; FunSel = 3'b010; I = 16'hFF00; tick();
        flags(1'b0, 1'b0, "load_noflag");
        FunSel = 3'b000; ClearFlags = 1'b1; tick();
        chk("dec_feff2", OutC, 16'hFEFF);
        flags(1'b1, 1'b0, "set_wins");
        ClearFlags = 1'b0; FunSel = 3'b011; tick();
        chk("sp_clr", OutC, 16'h0000);
        flags(1'b1, 1'b0, "clr_keeps");
        RegSel = 4'b1111; ClearFlags = 1'b1; tick();
        ClearFlags = 1'b0;
        flags(1'b0, 1'b0, "clr2");

        // Stack underflow at SP_HIGH with wrap
        RegSel = 4'b1011; FunSel = 3'b010; I = 16'hFFFF; tick();
        FunSel = 3'b001; tick();
        chk("sp_wrap", OutC, 16'h0000);
        flags(1'b0, 1'b1, "inc_top");
        RegSel = 4'b1110; FunSel = 3'b010; I = 16'hFFFF; OutCSel = 2'd0; tick();
        FunSel = 3'b001; tick();
        chk("pc_wrap", OutC, 16'h0000);
        flags(1'b0, 1'b1, "pc_noflag");

        // All registers increment together
        RegSel = 4'b0111; FunSel = 3'b010; I = 16'h0005; tick();
        RegSel = 4'b0000; FunSel = 3'b001; tick();
        RegSel = 4'b1111;
        rd(0, 16'h0001, "all_pc");
        rd(1, 16'h0001, "all_ar");
        rd(2, 16'h0001, "all_sp");
        OutCSel = 2'd3; OutDSel = 2'd3; #1;
        chk("both_r3_c", OutC, 16'h0006);
        chk("both_r3_d", OutD, 16'h0006);

        // Decrement wrap below zero
        RegSel = 4'b1101; FunSel = 3'b000; OutCSel = 2'd1; tick(); tick();
        chk("ar_dec_wrap", OutC, 16'hFFFF);
        RegSel = 4'b1111;
        rd(3, 16'h0006, "r3_held");

        // Reset overrides in-flight ops across an edge; first edge after runs
        RegSel = 4'b0000; FunSel = 3'b001;
        Reset = 1'b1; tick();
        rd(0, 16'h0000, "rst_mid_pc");
        rd(2, 16'hFFFF, "rst_mid_sp");
        flags(1'b0, 1'b0, "rst_mid");
        Reset = 1'b0; tick();
        rd(0, 16'h0001, "post_rst_pc");
        rd(2, 16'h0000, "post_rst_sp");
        flags(1'b0, 1'b1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/param_address_register_file.md
PARAM_ADDRESS_REGISTER_FILE -- requirements
Module: param_address_register_file

Interface
REQ-001 Parameter WIDTH, default 16: register and data width; SHALL be even and >= 4.
REQ-002 Parameter NREG, default 4: register count; SHALL be >= 3; index 0 = PC, 1 = AR, 2 = SP, 3..NREG-1 = general address registers.
REQ-003 Parameter PC_RESET, default 0: PC reset value.
REQ-004 Parameter SP_HIGH, default 16'hFFFF (WIDTH bits): SP reset value and upper stack limit.
REQ-005 Parameter SP_LOW, default 16'hFF00 (WIDTH bits): lower stack limit; SHALL be <= SP_HIGH.
REQ-006 Ports (SEL = $clog2(NREG) bits):
 Clock  in  1  single clock, rising edge.
 Reset  in  1  asynchronous, active-high.
 I  in  WIDTH  load data.
 RegSel  in  NREG  active-low per-register enable; bit k enables register k.
 FunSel  in  3  operation applied to every enabled register.
 OutCSel  in  SEL  read select, port C.
 OutDSel  in  SEL  read select, port D.
 ClearFlags  in  1  synchronous clear of sticky stack flags.
 OutC  out  WIDTH  register selected by OutCSel.
 OutD  out  WIDTH  register selected by OutDSel.
 SPOverflow  out  1  sticky: push past SP_LOW.
 SPUnderflow  out  1  sticky: pop past SP_HIGH.
REQ-007 One clock; reset is asynchronous and active-high, per the port list above.

Function
REQ-008 Each register with RegSel[k]==0 SHALL update on the rising Clock edge per FunSel; registers with RegSel[k]==1 SHALL hold.
REQ-009 FunSel encoding (H = WIDTH/2):
 000 Q-1.
 001 Q+1.
 010 Q=I.
 011 Q=0.
 100 Q[H-1:0]=I[H-1:0], upper half cleared.
 101 Q[H-1:0]=I[H-1:0], upper half held.
 110 Q[WIDTH-1:H]=I[H-1:0], lower half held.
 111 Q[H-1:0]=I[H-1:0], upper half = sign of I[H-1].
REQ-010 Increment and decrement SHALL wrap modulo 2^WIDTH; no saturation.
REQ-011 OutC and OutD SHALL be combinational from current register contents.
 - Select k < NREG outputs register k.
 - Select >= NREG outputs 0.
 - Both ports may select the same register.
REQ-012 Read during write SHALL return the pre-edge value; the new value is visible after the edge.
REQ-013 SPOverflow SHALL set on an edge where SP is enabled, FunSel==000, and SP==SP_LOW.
REQ-014 SPUnderflow SHALL set on an edge where SP is enabled, FunSel==001, and SP==SP_HIGH.
REQ-015 Flags SHALL hold until Reset, or until an edge with ClearFlags==1.
REQ-016 If a set condition and ClearFlags occur on the same edge, set SHALL win.
REQ-017 Loads and clears of SP (FunSel 010..111) SHALL NOT affect the flags.

Reset
REQ-018 While Reset==1, without waiting for Clock, all of the following SHALL hold:
 - PC = PC_RESET.
 - SP = SP_HIGH.
 - All other registers = 0.
 - SPOverflow = SPUnderflow = 0.
REQ-019 Reset asserted mid-operation SHALL override any in-flight FunSel.
REQ-020 The first edge after Reset deasserts SHALL execute normally.

Structure
REQ-021 A shared package SHALL hold:
 - FunSel encodings (FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LO_Z, FS_LO, FS_HI, FS_LO_SX).
 - Register index constants IDX_PC=0, IDX_AR=1, IDX_SP=2.
REQ-022 One sub-module, arf_register, SHALL be used:
 - Parameters: WIDTH and reset value.
 - Ports: Clock, Reset, I, E, FunSel, Q.
 - Instantiated NREG times via generate.
REQ-023 Stack flag logic SHALL reside in the top level, not in arf_register.

Verification (defaults: WIDTH=16, NREG=4)
REQ-024 Reset pulse -> PC=0000, SP=FFFF, AR=0000, R3=0000, both flags 0; asserting Reset without Clock clears a previously loaded AR=1234 immediately.
REQ-025 RegSel=1101, FunSel=010, I=ABCD, then FunSel=110 with I=0012 -> AR=ABCD, then AR=12CD; OutCSel=1 shows ABCD until the edge; OutDSel=0 stays 0000.
REQ-026 AR=00F0 with FunSel=111, I=0080 -> AR=FF80; with I=007F -> AR=007F; FunSel=100 on AR=ABCD with I=0055 -> AR=0055.
REQ-027 SP=FF01, two decrements (RegSel=1011, FunSel=000):
 - First decrement -> FF00, SPOverflow=0.
 - Second decrement -> FEFF, SPOverflow=1.
 - ClearFlags on the next idle edge -> SPOverflow=0.
 - ClearFlags together with a further push at FF00 -> SPOverflow stays 1.
REQ-028 SP=FFFF, one increment -> SP=0000 (wrap), SPUnderflow=1; PC=FFFF incremented -> 0000 with no flag change.
REQ-029 RegSel=0000, FunSel=001 -> all four registers increment on the same edge; OutCSel=OutDSel=3 both return R3.
